// File: rtl/vga_sync_module_if.sv
// Raster timing bundle from the VGA sync generator to the board renderer.
// The frame_cnt member exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_end;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        output pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start
`ifdef VGA_FRAME_CNT_EN
        , frame_cnt
`endif
    );

    modport slave (
        input pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start
`ifdef VGA_FRAME_CNT_EN
        , frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_module.sv
// Free-running VGA raster generator: 10-bit h/v counters with registered sync/flag decodes.
// Optional 8-bit frame counter is built when VGA_FRAME_CNT_EN is defined.
module vga_sync_module #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    vga_sync_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit window bounds so an end equal to 1024 still compares correctly
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    logic hsync_q;
    logic vsync_q;
    logic video_on_q;
    logic line_end_q;
    logic frame_start_q;

    logic hsync_nxt;
    logic vsync_nxt;
    logic video_on_nxt;
    logic line_end_nxt;
    logic frame_start_nxt;

    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + 10'd1;
            end
        end
    end

    // Flags decode the counter value being loaded, so they line up with pixel_x/pixel_y.
    always_comb begin
        hsync_nxt       = !(({1'b0, h_nxt} >= H_SYNC_BEG) && ({1'b0, h_nxt} < H_SYNC_END));
        vsync_nxt       = !(({1'b0, v_nxt} >= V_SYNC_BEG) && ({1'b0, v_nxt} < V_SYNC_END));
        video_on_nxt    = ({1'b0, h_nxt} < H_VIS_END) && ({1'b0, v_nxt} < V_VIS_END);
        line_end_nxt    = (h_nxt == H_LAST);
        frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    // Reset parks the raster on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_nxt;
            vsync_q       <= vsync_nxt;
            video_on_q    <= video_on_nxt;
            line_end_q    <= line_end_nxt;
            frame_start_q <= frame_start_nxt;
        end
    end

    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_end    = line_end_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic       started_q;

    // The wrap out of reset opens frame 0, so only later wraps advance the count.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
            started_q   <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (started_q && frame_start_nxt) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// Self-checking bench for vga_sync_module: default 800x525 and tiny 14x7 geometries
// against a cycle-index reference model; frame counter checked when VGA_FRAME_CNT_EN is defined.
module tb_vga_sync_module;

    logic clk_25MHz;
    logic rst_d_n;
    logic rst_s_n;

    int n_checks = 0;
    int n_errors = 0;

    // cycles since the first edge after reset release; -1 while in reset
    int cyc_d = -1;
    int cyc_s = -1;

    vga_sync_if if_d ();
    vga_sync_if if_s ();

    vga_sync_module dut_d (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_d_n),
        .vga       (if_d)
    );

    vga_sync_module #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) dut_s (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_s_n),
        .vga       (if_s)
    );

    logic [7:0] fc_d;
    logic [7:0] fc_s;
`ifdef VGA_FRAME_CNT_EN
    assign fc_d = if_d.frame_cnt;
    assign fc_s = if_s.frame_cnt;
`else
    assign fc_d = 8'd0;
    assign fc_s = 8'd0;
`endif

    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: position follows directly from the cycle index.
    task automatic check_dut(input string tag, input int cyc,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input int ox, input int oy, input int ohs, input int ovs,
                             input int ovon, input int ole, input int ofs, input int ofc);
        int ht, vt, h, v;
        int ex, ey, ehs, evs, evon, ele, efs, efc;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (cyc < 0) begin
            ex = ht - 1; ey = vt - 1; ehs = 1; evs = 1;
            evon = 0; ele = 0; efs = 0; efc = 0;
        end else begin
            h = cyc % ht;
            v = (cyc / ht) % vt;
            ex = h; ey = v;
            ehs = (h >= hv + hf && h < hv + hf + hsw) ? 0 : 1;
            evs = (v >= vv + vf && v < vv + vf + vsw) ? 0 : 1;
            evon = (h < hv && v < vv) ? 1 : 0;
            ele = (h == ht - 1) ? 1 : 0;
            efs = (h == 0 && v == 0) ? 1 : 0;
            efc = (cyc / (ht * vt)) % 256;
        end
        chk({tag, "_pixel_x"}, ox, ex);
        chk({tag, "_pixel_y"}, oy, ey);
        chk({tag, "_hsync"}, ohs, ehs);
        chk({tag, "_vsync"}, ovs, evs);
        chk({tag, "_video_on"}, ovon, evon);
        chk({tag, "_line_end"}, ole, ele);
        chk({tag, "_frame_start"}, ofs, efs);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, ofc, efc);
`endif
    endtask

    task automatic check_d(input string tag);
        check_dut(tag, cyc_d, 640, 16, 96, 48, 480, 10, 2, 33,
                  if_d.pixel_x, if_d.pixel_y, if_d.hsync, if_d.vsync,
                  if_d.video_on, if_d.line_end, if_d.frame_start, fc_d);
    endtask

    task automatic check_s(input string tag);
        check_dut(tag, cyc_s, 8, 2, 2, 2, 4, 1, 1, 1,
                  if_s.pixel_x, if_s.pixel_y, if_s.hsync, if_s.vsync,
                  if_s.video_on, if_s.line_end, if_s.frame_start, fc_s);
    endtask

    always @(posedge clk_25MHz) begin
        cyc_d = rst_d_n ? cyc_d + 1 : -1;
        cyc_s = rst_s_n ? cyc_s + 1 : -1;
    end
    always @(negedge rst_d_n) cyc_d = -1;
    always @(negedge rst_s_n) cyc_s = -1;

    always @(negedge clk_25MHz) begin
        check_d("d");
        check_s("s");
    end

    // Pulse-width and period measurements
    int hs_run_d = 0;
    int vs_run_s = 0;
    int cnt_s = 0;
    int last_fs_s = -1;
    always @(negedge clk_25MHz) begin
        if (rst_d_n && !if_d.hsync) begin
            hs_run_d++;
        end else if (hs_run_d > 0) begin
            chk("d_hsync_width", hs_run_d, 96);
            hs_run_d = 0;
        end
        if (!rst_s_n) begin
            vs_run_s = 0;
            last_fs_s = -1;
        end else begin
            cnt_s++;
            if (!if_s.vsync) begin
                vs_run_s++;
            end else if (vs_run_s > 0) begin
                chk("s_vsync_width", vs_run_s, 14);
                vs_run_s = 0;
            end
            if (if_s.frame_start) begin
                if (last_fs_s >= 0) chk("s_frame_period", cnt_s - last_fs_s, 98);
                last_fs_s = cnt_s;
            end
        end
    end

    task automatic wait_d(input int target);
        int g = 0;
        while (cyc_d != target && g < 5000) begin
            @(posedge clk_25MHz); #1;
            g++;
        end
        if (g >= 5000) chk("d_wait_timeout", cyc_d, target);
    endtask

    task automatic wait_s(input int target);
        int g = 0;
        while (cyc_s != target && g < 5000) begin
            @(posedge clk_25MHz); #1;
            g++;
        end
        if (g >= 5000) chk("s_wait_timeout", cyc_s, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, hold;
        rst_d_n = 1'b0;
        rst_s_n = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk_25MHz);
                #5 rst_d_n = 1'b1;
                wait_d(800 + 300);
                #4 rst_d_n = 1'b0;
                #1 check_d("d_async_rst");
                hold = $urandom_range(1, 4);
                repeat (hold) @(posedge clk_25MHz);
                #5 rst_d_n = 1'b1;
                repeat (1700 + $urandom_range(0, 200)) @(posedge clk_25MHz);
            end
            begin
                repeat (5 + $urandom_range(0, 3)) @(posedge clk_25MHz);
                #5 rst_s_n = 1'b1;
                k = $urandom_range(1, 4);
                wait_s(k * 98 + 2 * 14 + 3);
                #4 rst_s_n = 1'b0;
                #1 check_s("s_async_rst");
                hold = $urandom_range(1, 3);
                repeat (hold) @(posedge clk_25MHz);
                #5 rst_s_n = 1'b1;
                repeat (258 * 98 + $urandom_range(0, 97)) @(posedge clk_25MHz);
            end
        join
        @(negedge clk_25MHz);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
